// File: rtl/pw_requant_writer_pkg.sv
// Shared definitions for the point-wise requantise/write path: FSM encoding,
// default widths and the saturation / ReLU limit derivations.
package pw_requant_writer_pkg;

   localparam int SIZE_DEF  = 8;
   localparam int ACC_W_DEF = 24;
   localparam int ADDR_W    = 13;
   localparam int GRP_W     = 4;
   localparam int SHIFT_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } pw_state_e;

   // Largest value of a w-bit two's complement number.
   function automatic longint sat_max(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest value of a w-bit two's complement number.
   function automatic longint sat_min(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   // ReLU ceiling: largest pixel whose MSB stays clear.
   function automatic longint relu_max(input int size);
      return (64'sd1 <<< (size - 1)) - 64'sd1;
   endfunction

   // Clamp a wide intermediate into the w-bit signed range.
   function automatic longint sat_to(input longint x, input int w);
      longint r;
      if (x > sat_max(w)) begin
         r = sat_max(w);
      end else if (x < sat_min(w)) begin
         r = sat_min(w);
      end else begin
         r = x;
      end
      return r;
   endfunction

endpackage

// File: rtl/pw_requant_writer_if.sv
// Configuration, partial-sum stream and pixel write bus of the requant writer.
interface pw_requant_writer_if
   import pw_requant_writer_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int ACC_W = ACC_W_DEF
);
   logic                      start;
   logic [ADDR_W-1:0]         matrix2;
   logic [GRP_W-1:0]          groups;
   logic [SHIFT_W-1:0]        shift;
   logic signed [ACC_W-1:0]   bias;
   logic                      y_valid;
   logic signed [2*SIZE-2:0]  Y1;
   logic [SIZE-1:0]           out_data;
   logic [ADDR_W-1:0]         out_addr;
   logic                      out_we;
   logic                      busy;
   logic                      done;

   modport master (
      output start, matrix2, groups, shift, bias, y_valid, Y1,
      input  out_data, out_addr, out_we, busy, done
   );

   modport slave (
      input  start, matrix2, groups, shift, bias, y_valid, Y1,
      output out_data, out_addr, out_we, busy, done
   );
endinterface

// File: rtl/pw_round_clamp.sv
// Combinational bias add, round-half-up arithmetic shift and ReLU clamp.
// Shared by the point-wise and depth-wise output paths.
module pw_round_clamp
   import pw_requant_writer_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic signed [ACC_W-1:0] bias,
   input  logic [SHIFT_W-1:0]      shift,
   output logic [SIZE-1:0]         pix
);
   typedef logic signed [ACC_W-1:0] acc_t;

   localparam acc_t PIX_MAX = acc_t'(relu_max(SIZE));

   acc_t biased_s;
   acc_t half_s;
   acc_t rounded_s;
   acc_t shifted_s;

   // Both adds saturate so a large bias or rounding term can never wrap sign.
   always_comb begin
      biased_s = acc_t'(sat_to(longint'(acc) + longint'(bias), ACC_W));
      if (shift == {SHIFT_W{1'b0}}) begin
         half_s = {ACC_W{1'b0}};
      end else begin
         half_s = {{(ACC_W-1){1'b0}}, 1'b1} <<< (shift - 5'd1);
      end
      rounded_s = acc_t'(sat_to(longint'(biased_s) + longint'(half_s), ACC_W));
      shifted_s = rounded_s >>> shift;
      if (shifted_s[ACC_W-1]) begin
         pix = {SIZE{1'b0}};
      end else if (shifted_s > PIX_MAX) begin
         pix = PIX_MAX[SIZE-1:0];
      end else begin
         pix = shifted_s[SIZE-1:0];
      end
   end

endmodule

// File: rtl/pw_requant_writer.sv
// Accumulates the per-group partial sums of each output pixel, requantises
// the sum and writes one pixel per output address until the map is complete.
module pw_requant_writer
   import pw_requant_writer_pkg::*;
#(
   parameter int SIZE  = SIZE_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   pw_requant_writer_if.slave bus
);
   typedef logic signed [ACC_W-1:0] acc_t;

   pw_state_e           state_r;
   logic [GRP_W-1:0]    grp_r;
   logic [GRP_W-1:0]    groups_r;
   logic [ADDR_W-1:0]   pix_r;
   logic [ADDR_W-1:0]   last_pix_r;
   logic [SHIFT_W-1:0]  shift_r;
   acc_t                bias_r;
   acc_t                acc_r;
   acc_t                y_ext_s;
   acc_t                acc_next_s;
   logic [SIZE-1:0]     pix_s;
   logic [SIZE-1:0]     out_data_r;
   logic [ADDR_W-1:0]   out_addr_r;
   logic                out_we_r;
   logic                busy_r;
   logic                done_r;

   // Running pixel sum including the current partial sum; group 0 restarts it.
   always_comb begin
      y_ext_s = acc_t'(bus.Y1);
      if (grp_r == {GRP_W{1'b0}}) begin
         acc_next_s = y_ext_s;
      end else begin
         acc_next_s = acc_t'(sat_to(longint'(acc_r) + longint'(y_ext_s), ACC_W));
      end
   end

   // The pixel is requantised straight from the final sum so the write
   // lands one cycle after the last group arrives.
   pw_round_clamp #(
      .SIZE  (SIZE),
      .ACC_W (ACC_W)
   ) u_round_clamp (
      .acc   (acc_next_s),
      .bias  (bias_r),
      .shift (shift_r),
      .pix   (pix_s)
   );

   // Map sequencing: configuration latch, group/pixel counting and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         grp_r      <= {GRP_W{1'b0}};
         groups_r   <= {GRP_W{1'b0}};
         pix_r      <= {ADDR_W{1'b0}};
         last_pix_r <= {ADDR_W{1'b0}};
         shift_r    <= {SHIFT_W{1'b0}};
         bias_r     <= {ACC_W{1'b0}};
         acc_r      <= {ACC_W{1'b0}};
         out_data_r <= {SIZE{1'b0}};
         out_addr_r <= {ADDR_W{1'b0}};
         out_we_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         out_we_r <= 1'b0;
         done_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  groups_r   <= bus.groups;
                  shift_r    <= bus.shift;
                  bias_r     <= bus.bias;
                  // An empty map is run as a single pixel.
                  last_pix_r <= (bus.matrix2 == {ADDR_W{1'b0}}) ? {ADDR_W{1'b0}}
                                                                : bus.matrix2 - 13'd1;
                  grp_r      <= {GRP_W{1'b0}};
                  pix_r      <= {ADDR_W{1'b0}};
                  acc_r      <= {ACC_W{1'b0}};
                  busy_r     <= 1'b1;
                  state_r    <= ST_ACC;
               end
            end
            ST_ACC: begin
               if (bus.y_valid) begin
                  acc_r <= acc_next_s;
                  if (grp_r == groups_r) begin
                     grp_r      <= {GRP_W{1'b0}};
                     out_data_r <= pix_s;
                     out_addr_r <= pix_r;
                     out_we_r   <= 1'b1;
                     state_r    <= ST_WRITE;
                  end else begin
                     grp_r <= grp_r + 4'd1;
                  end
               end
            end
            ST_WRITE: begin
               // Partial sums arriving here are a protocol violation and dropped.
               pix_r <= pix_r + 13'd1;
               if (pix_r == last_pix_r) begin
                  done_r  <= 1'b1;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_ACC;
               end
            end
            ST_DONE: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.out_data = out_data_r;
   assign bus.out_addr = out_addr_r;
   assign bus.out_we   = out_we_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_pw_requant_writer.sv
// Self-checking bench for pw_requant_writer: single-pixel vector table plus
// hand-written multi-pixel, abort and full-map sequences, scored by a queue.
module tb_pw_requant_writer;
   import pw_requant_writer_pkg::*;

   localparam int SIZE  = 8;
   localparam int ACC_W = 16;

   typedef logic signed [2*SIZE-2:0] y_t;
   typedef logic signed [ACC_W-1:0]  b_t;

   typedef struct {
      int addr;
      int data;
   } exp_t;

   typedef struct {
      int g;
      int sh;
      int b;
      int y[4];
      int exp_pix;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   pw_requant_writer_if #(.SIZE(SIZE), .ACC_W(ACC_W)) bus ();

   pw_requant_writer #(.SIZE(SIZE), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   done_cnt  = 0;
   int   maps_exp  = 0;
   int   last_addr = -1;
   logic prev_last_we = 1'b0;
   logic prev_done    = 1'b0;
   vec_t vt[16];

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Scoreboard: every write is popped against the queue; done must follow the last write.
   always @(negedge clk) begin
      if (bus.out_we) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: got write addr %0d data %0d, required none",
                     int'(bus.out_addr), int'(bus.out_data));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_addr", int'(bus.out_addr), e.addr);
            check("wr_data", int'(bus.out_data), e.data);
         end
      end
      if (bus.done) begin
         done_cnt <= done_cnt + 1;
         check("done_after_last_write", int'(prev_last_we), 1);
      end
      if (prev_done) begin
         check("busy_low_after_done", int'(bus.busy), 0);
      end
      prev_last_we <= bus.out_we && (int'(bus.out_addr) == last_addr);
      prev_done    <= bus.done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_map(input int m2, input int g, input int sh, input int b);
      bus.matrix2 = 13'(m2);
      bus.groups  = 4'(g);
      bus.shift   = 5'(sh);
      bus.bias    = b_t'(b);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      check("busy_after_start", int'(bus.busy), 1);
   endtask

   // Drives groups g+1 partial sums back to back, then one gap cycle
   // (optionally carrying a stray valid that the DUT must drop).
   task automatic send_pixel(input int g, input int ys[4], input bit stray);
      for (int k = 0; k <= g; k++) begin
         bus.y_valid = 1'b1;
         bus.Y1      = y_t'(ys[(k > 3) ? 3 : k]);
         tick();
      end
      bus.y_valid = stray;
      bus.Y1      = y_t'(1000);
      tick();
      bus.y_valid = 1'b0;
      bus.Y1      = y_t'(0);
   endtask

   task automatic send_one(input int v);
      int ys[4];
      for (int k = 0; k < 4; k++) ys[k] = v;
      send_pixel(0, ys, 1'b0);
   endtask

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      while (bus.done !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("done_seen", int'(bus.done), 1);
      tick();
      check("sb_empty", sb.size(), 0);
   endtask

   initial begin
      // groups, shift, bias, partial sums, expected pixel
      vt[0]  = '{2,  2, 3,     '{10, 20, 30, 30},               16};
      vt[1]  = '{0,  0, 0,     '{5, 5, 5, 5},                   5};
      vt[2]  = '{0,  0, 0,     '{-3, -3, -3, -3},               0};
      vt[3]  = '{0,  0, 0,     '{200, 200, 200, 200},           127};
      vt[4]  = '{1,  1, 0,     '{100, 55, 55, 55},              78};
      vt[5]  = '{3,  4, -40,   '{100, 100, 100, 100},           23};
      vt[6]  = '{0,  3, 0,     '{-20, -20, -20, -20},           0};
      vt[7]  = '{0,  1, 0,     '{3, 3, 3, 3},                   2};
      vt[8]  = '{2,  0, 32767, '{-16384, -16384, -16384, 0},    0};
      vt[9]  = '{15, 9, -1,    '{16383, 16383, 16383, 16383},   63};
      vt[10] = '{0,  4, 0,     '{2023, 2023, 2023, 2023},       126};
      vt[11] = '{0,  8, 32767, '{16383, 16383, 16383, 16383},   127};
      vt[12] = '{15, 8, -1,    '{16383, 16383, 16383, 16383},   127};
      vt[13] = '{0,  0, 0,     '{127, 127, 127, 127},           127};
      vt[14] = '{0,  0, 0,     '{128, 128, 128, 128},           127};
      vt[15] = '{0,  0, 0,     '{0, 0, 0, 0},                   0};

      rst_n       = 1'b0;
      bus.start   = 1'b0;
      bus.matrix2 = 13'd0;
      bus.groups  = 4'd0;
      bus.shift   = 5'd0;
      bus.bias    = b_t'(0);
      bus.y_valid = 1'b0;
      bus.Y1      = y_t'(0);
      repeat (3) tick();
      check("rst_out_data", int'(bus.out_data), 0);
      check("rst_out_addr", int'(bus.out_addr), 0);
      check("rst_out_we",   int'(bus.out_we),   0);
      check("rst_busy",     int'(bus.busy),     0);
      check("rst_done",     int'(bus.done),     0);
      rst_n = 1'b1;
      tick();

      // Single-pixel vector table.
      for (int r = 0; r < 16; r++) begin
         last_addr = 0;
         start_map(1, vt[r].g, vt[r].sh, vt[r].b);
         sb.push_back('{0, vt[r].exp_pix});
         send_pixel(vt[r].g, vt[r].y, 1'b0);
         maps_exp++;
         wait_done(60);
      end

      // Four-pixel map, one group each.
      last_addr = 3;
      start_map(4, 0, 0, 0);
      sb.push_back('{0, 5});
      sb.push_back('{1, 0});
      sb.push_back('{2, 127});
      sb.push_back('{3, 127});
      send_one(5);
      send_one(-3);
      send_one(200);
      send_one(127);
      maps_exp++;
      wait_done(20);

      // Partial sums in IDLE are ignored.
      bus.y_valid = 1'b1;
      bus.Y1      = y_t'(77);
      repeat (3) tick();
      bus.y_valid = 1'b0;
      check("idle_valid_busy", int'(bus.busy), 0);

      // Start while busy is ignored; a stray valid during WRITE is dropped.
      begin
         int ys[4];
         last_addr = 1;
         start_map(2, 1, 0, 0);
         sb.push_back('{0, 30});
         ys = '{10, 20, 20, 20};
         send_pixel(1, ys, 1'b1);
         bus.groups  = 4'd0;
         bus.matrix2 = 13'd1;
         bus.start   = 1'b1;
         tick();
         bus.start   = 1'b0;
         sb.push_back('{1, 3});
         ys = '{1, 2, 2, 2};
         send_pixel(1, ys, 1'b0);
         maps_exp++;
         wait_done(20);
      end
      last_addr = 0;
      start_map(1, 0, 0, 0);
      sb.push_back('{0, 9});
      send_one(9);
      maps_exp++;
      wait_done(20);

      // Reset in the middle of a map aborts it.
      last_addr = 3;
      start_map(4, 0, 0, 0);
      sb.push_back('{0, 11});
      sb.push_back('{1, 12});
      send_one(11);
      send_one(12);
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_out_data", int'(bus.out_data), 0);
      check("abort_out_addr", int'(bus.out_addr), 0);
      check("abort_out_we",   int'(bus.out_we),   0);
      check("abort_busy",     int'(bus.busy),     0);
      check("abort_done",     int'(bus.done),     0);
      bus.y_valid = 1'b1;
      bus.Y1      = y_t'(50);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      bus.y_valid = 1'b0;
      check("abort_idle_busy", int'(bus.busy), 0);
      check("abort_sb_empty", sb.size(), 0);
      last_addr = 1;
      start_map(2, 0, 0, 0);
      sb.push_back('{0, 21});
      sb.push_back('{1, 22});
      send_one(21);
      send_one(22);
      maps_exp++;
      wait_done(20);

      // Largest map.
      last_addr = 4095;
      start_map(4096, 0, 0, 0);
      for (int i = 0; i < 4096; i++) begin
         sb.push_back('{i, i % 128});
         send_one(i % 128);
      end
      maps_exp++;
      wait_done(20);
      repeat (3) tick();
      check("final_busy", int'(bus.busy), 0);
      check("done_pulse_count", done_cnt, maps_exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
